aha_sif_arbiter: RTL and testbench

Shares the single CGRA simple data interface (SIF: proc_packet write/read port, in-order read data, no backpressure) between two requesters, e.g. the AXI-to-SIF bridge and a DMA engine. Round-robin arbitrates one command per cycle, drives registered SIF write/read strobes, and tracks outstanding reads in a tag FIFO so each in-order read response returns to the requester that issued it. Sits between the requesters and the CGRA proc_packet pins.

---
 rtl/aha_sif_arb_pkg.sv | 12 +
 rtl/aha_sif_tag_fifo.sv | 70 +++++++
 rtl/aha_sif_arbiter.sv | 169 ++++++++++++++++
 tb/tb_aha_sif_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aha_sif_arb_pkg.sv
// Shared types and sizing helpers for the two-requester SIF arbiter.
package aha_sif_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef logic req_id_t;

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/aha_sif_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding SIF read.
module aha_sif_tag_fifo
  import aha_sif_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/aha_sif_arbiter.sv
// Round-robin arbiter sharing one CGRA SIF port between two requesters,
// routing in-order read responses back to the issuing requester.
module aha_sif_arbiter
  import aha_sif_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 22,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [NUM_REQ-1:0]                       REQ_VALID,
  input  logic [NUM_REQ-1:0]                       REQ_WRITE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]            REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            REQ_WDATA,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]        REQ_WSTRB,
  output logic [NUM_REQ-1:0]                       REQ_READY,
  output logic [NUM_REQ-1:0]                       RSP_VALID,
  output logic [DATA_WIDTH-1:0]                    RSP_DATA,
  output logic [ADDR_WIDTH-1:0]                    SIF_WR_ADDR,
  output logic                                     SIF_WR_EN,
  output logic [DATA_WIDTH-1:0]                    SIF_WR_DATA,
  output logic [DATA_WIDTH/8-1:0]                  SIF_WR_STRB,
  output logic [ADDR_WIDTH-1:0]                    SIF_RD_ADDR,
  output logic                                     SIF_RD_EN,
  input  logic [DATA_WIDTH-1:0]                    SIF_RD_DATA,
  input  logic                                     SIF_RD_VALID,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]    RD_OUTSTANDING,
  output logic                                     ERR_UNEXPECTED
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = cnt_width(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];
  logic [STRB_W-1:0]     req_wstrb [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  req_id_t            gnt_idx;
  logic               gnt_write;

  req_id_t               rr_q, rr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0]     wr_strb_q, wr_strb_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  logic             fifo_push;
  logic             fifo_pop;
  req_id_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i]  = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata[i] = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign req_wstrb[i] = REQ_WSTRB[i*STRB_W +: STRB_W];
  end

  // Reads need a free tag slot based on the registered count; writes never wait.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      elig[i] = !RESET && REQ_VALID[i] && (REQ_WRITE[i] || !fifo_full);
    end
    gnt_any   = |elig;
    gnt_idx   = (&elig) ? rr_q : req_id_t'(elig[1]);
    gnt       = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    gnt_write = REQ_WRITE[gnt_idx];
  end

  assign fifo_push = gnt_any && !gnt_write;
  assign fifo_pop  = SIF_RD_VALID && !fifo_empty;

  always_comb begin
    rr_d        = rr_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    if (gnt_any) begin
      rr_d = ~gnt_idx;
      if (gnt_write) begin
        wr_en_d   = 1'b1;
        wr_addr_d = req_addr[gnt_idx];
        wr_data_d = req_wdata[gnt_idx];
        wr_strb_d = req_wstrb[gnt_idx];
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = req_addr[gnt_idx];
      end
    end
    if (fifo_pop) begin
      rsp_valid_d = NUM_REQ'(1) << fifo_head;
      rsp_data_d  = SIF_RD_DATA;
    end
    if (SIF_RD_VALID && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_q        <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  aha_sif_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk     (CLK),
    .reset   (RESET),
    .push    (fifo_push),
    .push_id (gnt_idx),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign REQ_READY      = gnt;
  assign RSP_VALID      = rsp_valid_q;
  assign RSP_DATA       = rsp_data_q;
  assign SIF_WR_ADDR    = wr_addr_q;
  assign SIF_WR_EN      = wr_en_q;
  assign SIF_WR_DATA    = wr_data_q;
  assign SIF_WR_STRB    = wr_strb_q;
  assign SIF_RD_ADDR    = rd_addr_q;
  assign SIF_RD_EN      = rd_en_q;
  assign RD_OUTSTANDING = fifo_count;
  assign ERR_UNEXPECTED = err_q;

endmodule

// File: tb/tb_aha_sif_arbiter.sv
// Self-checking bench for aha_sif_arbiter: directed scenarios plus a randomized run
// against a queue-based model of grants, issue order and tag routing.
module tb_aha_sif_arbiter;

  localparam int AW = 22;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int MO = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [1:0]      req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   sif_wr_addr, sif_rd_addr;
  logic            sif_wr_en, sif_rd_en;
  logic [DW-1:0]   sif_wr_data, sif_rd_data;
  logic [SW-1:0]   sif_wr_strb;
  logic            sif_rd_valid;
  logic [CW-1:0]   rd_outstanding;
  logic            err_unexpected;

  int checks = 0;
  int errors = 0;

  aha_sif_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .CLK(clk), .RESET(reset), .REQ_VALID(req_valid), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_WSTRB(req_wstrb),
    .REQ_READY(req_ready), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .SIF_WR_ADDR(sif_wr_addr), .SIF_WR_EN(sif_wr_en), .SIF_WR_DATA(sif_wr_data),
    .SIF_WR_STRB(sif_wr_strb), .SIF_RD_ADDR(sif_rd_addr), .SIF_RD_EN(sif_rd_en),
    .SIF_RD_DATA(sif_rd_data), .SIF_RD_VALID(sif_rd_valid),
    .RD_OUTSTANDING(rd_outstanding), .ERR_UNEXPECTED(err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    sif_rd_valid = 1'b0; sif_rd_data = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = v; req_write[i] = w;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    set_req(0, 1'b1, 1'b1, 22'h11, 64'h1, 8'hFF);
    set_req(1, 1'b1, 1'b1, 22'h22, 64'h2, 8'hFF);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data, sif_wr_en, sif_rd_en, sif_wr_addr, sif_wr_data, sif_wr_strb, sif_rd_addr} !== '0)
      begin errors++; $display("FAIL reset_outputs got nonzero rsp_valid=%b wr_en=%b rd_en=%b wr_addr=%h", rsp_valid, sif_wr_en, sif_rd_en, sif_wr_addr); end
    checks++; if ({rd_outstanding, err_unexpected} !== '0) begin errors++; $display("FAIL reset_count got %0d err %b exp 0 0", rd_outstanding, err_unexpected); end
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({sif_wr_en, sif_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_no_issue got %b exp 00", {sif_wr_en, sif_rd_en}); end
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 1'b1, 1'b1, 22'h000100, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sw_ready got %b exp 01", req_ready); end
    @(negedge clk);
    clear_inputs();
    checks++; if ({sif_wr_en, sif_rd_en} !== 2'b10) begin errors++; $display("FAIL sw_en got %b exp 10", {sif_wr_en, sif_rd_en}); end
    checks++; if (sif_wr_addr !== 22'h000100) begin errors++; $display("FAIL sw_addr got %h exp 000100", sif_wr_addr); end
    checks++; if (sif_wr_data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL sw_data got %h exp deadbeefcafef00d", sif_wr_data); end
    checks++; if (sif_wr_strb !== 8'hFF) begin errors++; $display("FAIL sw_strb got %h exp ff", sif_wr_strb); end
    @(negedge clk);
    checks++; if (sif_wr_en !== 1'b0) begin errors++; $display("FAIL sw_en_drop got %b exp 0", sif_wr_en); end
    checks++; if (sif_wr_addr !== 22'h000100) begin errors++; $display("FAIL sw_addr_hold got %h exp 000100", sif_wr_addr); end
  endtask

  task automatic test_contention();
    logic [1:0]    exp_rdy;
    logic [AW-1:0] exp_addr;
    do_reset();
    set_req(0, 1'b1, 1'b1, 22'h10, 64'hA0, 8'h0F);
    set_req(1, 1'b1, 1'b1, 22'h20, 64'hB0, 8'hF0);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 22'h10 : 22'h20;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      @(negedge clk);
      checks++; if (!(sif_wr_en === 1'b1 && sif_wr_addr === exp_addr))
        begin errors++; $display("FAIL rr_issue[%0d] got en=%b addr=%h exp en=1 addr=%h", k, sif_wr_en, sif_wr_addr, exp_addr); end
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_read();
    do_reset();
    set_req(1, 1'b1, 1'b0, 22'h40, 64'h0, 8'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got %b exp 10", req_ready); end
    @(negedge clk);
    clear_inputs();
    checks++; if (!(sif_rd_en === 1'b1 && sif_wr_en === 1'b0 && sif_rd_addr === 22'h40))
      begin errors++; $display("FAIL rd_issue got rd_en=%b wr_en=%b addr=%h exp 1 0 40", sif_rd_en, sif_wr_en, sif_rd_addr); end
    checks++; if (rd_outstanding !== 3'd1) begin errors++; $display("FAIL rd_cnt1 got %0d exp 1", rd_outstanding); end
    repeat (3) @(negedge clk);
    sif_rd_valid = 1'b1; sif_rd_data = 64'h1234;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_rsp got %b exp 00", rsp_valid); end
    @(negedge clk);
    sif_rd_valid = 1'b0; sif_rd_data = 64'hFFFF;
    checks++; if (!(rsp_valid === 2'b10 && rsp_data === 64'h1234))
      begin errors++; $display("FAIL rd_rsp got %b %h exp 10 1234", rsp_valid, rsp_data); end
    checks++; if (rd_outstanding !== 3'd0) begin errors++; $display("FAIL rd_cnt0 got %0d exp 0", rd_outstanding); end
    @(negedge clk);
    checks++; if (!(rsp_valid === 2'b00 && rsp_data === 64'h1234))
      begin errors++; $display("FAIL rd_rsp_hold got %b %h exp 00 1234", rsp_valid, rsp_data); end
  endtask

  task automatic test_full();
    do_reset();
    set_req(0, 1'b1, 1'b0, 22'h80, 64'h0, 8'h0);
    for (int k = 0; k < MO; k++) begin
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_fill_ready[%0d] got %b exp 01", k, req_ready); end
      @(negedge clk);
    end
    checks++; if (rd_outstanding !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", rd_outstanding); end
    set_req(1, 1'b1, 1'b1, 22'h99, 64'h77, 8'h3C);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL full_wr_ready got %b exp 10", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 22'h0, 64'h0, 8'h0);
    checks++; if (!(sif_wr_en === 1'b1 && sif_rd_en === 1'b0 && sif_wr_addr === 22'h99))
      begin errors++; $display("FAIL full_wr_issue got wr=%b rd=%b addr=%h exp 1 0 99", sif_wr_en, sif_rd_en, sif_wr_addr); end
    sif_rd_valid = 1'b1; sif_rd_data = 64'h55;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_pop_same_cycle got %b exp 00", req_ready); end
    @(negedge clk);
    sif_rd_valid = 1'b0;
    checks++; if (!(rd_outstanding === 3'd3 && rsp_valid === 2'b01))
      begin errors++; $display("FAIL full_pop got cnt=%0d rsp=%b exp 3 01", rd_outstanding, rsp_valid); end
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_regrant got %b exp 01", req_ready); end
    @(negedge clk);
    clear_inputs();
    checks++; if (!(sif_rd_en === 1'b1 && rd_outstanding === 3'd4))
      begin errors++; $display("FAIL full_reissue got rd_en=%b cnt=%0d exp 1 4", sif_rd_en, rd_outstanding); end
    do_reset();
    checks++; if (rd_outstanding !== 3'd0) begin errors++; $display("FAIL full_reset_drop got %0d exp 0", rd_outstanding); end
  endtask

  task automatic test_routing();
    logic [DW-1:0] vals [3];
    logic [1:0]    exp_v [3];
    vals[0] = 64'hAAAA_0001; vals[1] = 64'hBBBB_0002; vals[2] = 64'hCCCC_0003;
    exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      set_req(k % 2, 1'b1, 1'b0, AW'(k + 1), 64'h0, 8'h0);
      #1;
      checks++; if (req_ready !== exp_v[k]) begin errors++; $display("FAIL route_ready[%0d] got %b exp %b", k, req_ready, exp_v[k]); end
      @(negedge clk);
    end
    clear_inputs();
    checks++; if (rd_outstanding !== 3'd3) begin errors++; $display("FAIL route_cnt got %0d exp 3", rd_outstanding); end
    for (int k = 0; k < 3; k++) begin
      sif_rd_valid = 1'b1; sif_rd_data = vals[k];
      @(negedge clk);
      checks++; if (!(rsp_valid === exp_v[k] && rsp_data === vals[k]))
        begin errors++; $display("FAIL route_rsp[%0d] got %b %h exp %b %h", k, rsp_valid, rsp_data, exp_v[k], vals[k]); end
    end
    sif_rd_valid = 1'b0;
    @(negedge clk);
    checks++; if (!(rsp_valid === 2'b00 && rd_outstanding === 3'd0))
      begin errors++; $display("FAIL route_drain got %b %0d exp 00 0", rsp_valid, rd_outstanding); end
  endtask

  task automatic test_unexpected();
    do_reset();
    sif_rd_valid = 1'b1; sif_rd_data = 64'h9999;
    @(negedge clk);
    sif_rd_valid = 1'b0;
    checks++; if (!(err_unexpected === 1'b1 && rsp_valid === 2'b00 && rd_outstanding === 3'd0))
      begin errors++; $display("FAIL unexp_set got err=%b rsp=%b cnt=%0d exp 1 00 0", err_unexpected, rsp_valid, rd_outstanding); end
    repeat (3) @(negedge clk);
    checks++; if (!(err_unexpected === 1'b1 && rsp_valid === 2'b00))
      begin errors++; $display("FAIL unexp_sticky got err=%b rsp=%b exp 1 00", err_unexpected, rsp_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL unexp_clear got %b exp 0", err_unexpected); end
  endtask

  // Random traffic; the model tracks grants, issued strobes and a queue of tags.
  task automatic test_random();
    bit            m_rr;
    int            m_tags[$];
    int            m_due[$];
    int            last_due;
    bit            pend [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [SW-1:0] s [2];
    logic          w [2];
    logic          v [2];
    logic          e_wr_en, e_rd_en;
    logic [AW-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_wr_data, e_rsp_data;
    logic [SW-1:0] e_wr_strb;
    logic [1:0]    e_rsp_valid, e_rdy;
    bit            el0, el1;
    int            g;
    do_reset();
    m_rr = 0; last_due = 0;
    pend[0] = 0; pend[1] = 0;
    e_wr_en = 0; e_rd_en = 0; e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_wr_strb = '0;
    e_rsp_valid = '0; e_rsp_data = '0;
    for (int t = 0; t < 600; t++) begin
      checks++; if ({sif_wr_en, sif_rd_en, sif_wr_addr, sif_wr_data, sif_wr_strb, sif_rd_addr} !==
                    {e_wr_en, e_rd_en, e_wr_addr, e_wr_data, e_wr_strb, e_rd_addr})
        begin errors++; $display("FAIL rand_issue t=%0d got wr=%b rd=%b wa=%h wd=%h ws=%h ra=%h exp wr=%b rd=%b wa=%h wd=%h ws=%h ra=%h",
          t, sif_wr_en, sif_rd_en, sif_wr_addr, sif_wr_data, sif_wr_strb, sif_rd_addr, e_wr_en, e_rd_en, e_wr_addr, e_wr_data, e_wr_strb, e_rd_addr); end
      checks++; if ({rsp_valid, rsp_data, rd_outstanding, err_unexpected} !== {e_rsp_valid, e_rsp_data, CW'(m_tags.size()), 1'b0})
        begin errors++; $display("FAIL rand_rsp t=%0d got v=%b d=%h cnt=%0d err=%b exp v=%b d=%h cnt=%0d err=0",
          t, rsp_valid, rsp_data, rd_outstanding, err_unexpected, e_rsp_valid, e_rsp_data, m_tags.size()); end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          w[i] = $urandom_range(0, 1);
          a[i] = AW'($urandom);
          d[i] = {$urandom, $urandom};
          s[i] = SW'($urandom);
        end
        set_req(i, v[i], w[i], a[i], d[i], s[i]);
      end
      sif_rd_data = {$urandom, $urandom};
      sif_rd_valid = (m_due.size() > 0 && m_due[0] <= t);
      if (sif_rd_valid) void'(m_due.pop_front());
      #1;
      el0 = v[0] && (w[0] || m_tags.size() < MO);
      el1 = v[1] && (w[1] || m_tags.size() < MO);
      g = (el0 && el1) ? int'(m_rr) : (el1 ? 1 : (el0 ? 0 : -1));
      e_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      checks++; if (req_ready !== e_rdy) begin errors++; $display("FAIL rand_ready t=%0d got %b exp %b", t, req_ready, e_rdy); end
      pend[0] = v[0] && (g != 0);
      pend[1] = v[1] && (g != 1);
      e_rsp_valid = 2'b00;
      if (sif_rd_valid && m_tags.size() > 0) begin
        e_rsp_valid = (m_tags[0] == 0) ? 2'b01 : 2'b10;
        e_rsp_data  = sif_rd_data;
        void'(m_tags.pop_front());
      end
      e_wr_en = 0; e_rd_en = 0;
      if (g >= 0) begin
        m_rr = (g == 0);
        if (w[g]) begin
          e_wr_en = 1; e_wr_addr = a[g]; e_wr_data = d[g]; e_wr_strb = s[g];
        end else begin
          e_rd_en = 1; e_rd_addr = a[g];
          m_tags.push_back(g);
          last_due = (t + 1 + $urandom_range(1, 6) > last_due + 1) ? t + 1 + $urandom_range(1, 6) : last_due + 1;
          m_due.push_back(last_due);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_read();
    test_full();
    test_routing();
    test_unexpected();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
